trig_activity_detect: RTL and testbench
=======================================

# trig_activity_detect

Conditions one asynchronous trigger input for front-panel activity indication and statistics. It synchronizes the raw input and rejects glitches shorter than a programmable length. It then emits single-cycle activity pulses on the selected edge(s) and keeps saturating event and glitch counters. The `activity` output drives the LED pulse stretcher directly downstream, one instance per trigger channel.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer flop count, minimum 2.
- `FILTER_BITS`, default 4: width of `filter_len`.
- `COUNT_WIDTH`, default 32: width of `event_count`.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  reset, asynchronous, active-high.
- `trig_in`  in  1  raw trigger, asynchronous to `clk`.
- `edge_mode`  in  2  edge select: 00 = none, 01 = rising, 10 = falling, 11 = both. Quasi-static.
- `filter_len`  in  FILTER_BITS  extra stable cycles required before a transition is accepted.
- `count_clear`  in  1  single-cycle request to zero both counters.
- `level`  out  1  filtered input level.
- `activity`  out  1  one-cycle pulse per accepted selected edge.
- `event_count`  out  COUNT_WIDTH  count of accepted selected edges, saturating.
- `glitch_count`  out  16  count of rejected transitions, saturating.
- `count_saturated`  out  1  sticky flag, set when `event_count` reaches all-ones.

## Operation
**Reset.** `rst` asynchronously clears everything: synchronizer flops, filter counter, all outputs, and the state machine (which returns to STABLE_LOW).

**Synchronizer.** `sync_q` is the output of a chain of `SYNC_STAGES` flops. Nothing else samples `trig_in`.

**Filter state machine.** Filter counter `fc` is FILTER_BITS wide.
- STABLE_LOW, `sync_q`=1:
  - If `filter_len`==0: set `level`<=1, accept the rising edge, go to STABLE_HIGH.
  - Otherwise: set `fc`<=1, go to PEND_HIGH.
- PEND_HIGH:
  - `sync_q`=0: go to STABLE_LOW and count a glitch.
  - Else if `fc` >= `filter_len`: set `level`<=1, accept the rising edge, go to STABLE_HIGH.
  - Else: `fc`++.
- STABLE_HIGH and PEND_LOW mirror the above with polarities swapped. The accepted edge is falling.
- `filter_len` is compared live. Lowering it while pending completes the transition on the next cycle (this is why the test is >=, not ==).

**Activity.** `activity`<=1 for exactly one cycle when an accepted edge matches `edge_mode`. It is registered in the same edge that updates `level`.
- `level` tracks the input regardless of `edge_mode`.
- With `edge_mode`=00, `activity` never asserts and `event_count` never increments.

**Event counter.**
- Increments on each `activity` pulse. Holds at all-ones.
- `count_saturated` sets on the edge where the counter becomes all-ones and stays set until cleared.

**Glitch counter.**
- Increments on each PEND→STABLE return to the old level. Holds at 0xFFFF.

**Clear.** `count_clear` zeros `event_count`, `glitch_count` and `count_saturated` on the next edge.
- Clear coinciding with an event yields `event_count`=1.
- Clear coinciding with a glitch yields `glitch_count`=1.
- No event or glitch is lost.

**Input high at reset release.** Reported as a normal rising edge after the standard latency.

## Timing
- Define `trig_in` as stable at the new value before clock edge 1. Then `level` and `activity` change after edge `SYNC_STAGES`+1+`filter_len`.
  - Defaults, `filter_len`=0: edge 3.
- Rejection: a pulse is rejected if `sync_q` holds the new value for ≤`filter_len` cycles. It is accepted at `filter_len`+1 cycles.
- `activity` width is always 1 cycle. The minimum spacing between pulses is `filter_len`+1 cycles.
- `event_count` updates in the cycle after `activity` is high.
- `glitch_count` updates one cycle after the rejecting sample.
- No combinational paths from inputs to outputs.

## Test plan
- Reset, defaults, `trig_in` 0→1 before edge 1, `filter_len`=0, `edge_mode`=01 → `level`=1 and `activity` one pulse after edge 3, `event_count`=1.
- `filter_len`=3, 3-cycle high pulse at `sync_q` → no `activity`, `level` stays 0, `glitch_count`=1. Repeat with a 4-cycle pulse → one `activity` pulse, `event_count`=1.
- `edge_mode`=11, five full high/low periods of 10 cycles each → 10 `activity` pulses, `event_count`=10. Same stimulus with `edge_mode`=10 → 5 pulses. With `edge_mode`=00 → 0 pulses, `level` still toggles.
- Preload near saturation with COUNT_WIDTH=4 and 17 accepted edges → `event_count`=15 and `count_saturated`=1. Then pulse `count_clear` → both 0.
- `count_clear` in the same cycle as `activity` → `event_count`=1 the next cycle.
- Assert `rst` while in PEND_HIGH with `fc`=2 → all outputs 0 immediately. With the input held high, a rising edge is re-reported after the full latency.

Source files
------------

// File: rtl/trig_activity_detect.sv
// trig_activity_detect
// Conditions one asynchronous trigger input for activity indication and
// statistics. The raw input is synchronized, glitches shorter than
// filter_len+1 cycles are rejected, and accepted edges that match
// edge_mode produce single-cycle activity pulses. Saturating event and
// glitch counters are kept alongside.
//
// Ports:
//   clk             system clock
//   rst             asynchronous active-high reset
//   trig_in         raw trigger, asynchronous to clk
//   edge_mode       00 none, 01 rising, 10 falling, 11 both (quasi-static)
//   filter_len      extra stable cycles required before a transition is accepted
//   count_clear     single-cycle request to zero both counters
//   level           filtered input level
//   activity        one-cycle pulse per accepted selected edge
//   event_count     saturating count of activity pulses
//   glitch_count    saturating count of rejected transitions
//   count_saturated sticky, set when event_count reaches all-ones
//
// state       | meaning
// STABLE_LOW  | filtered level is 0, input agrees
// PEND_HIGH   | input went high, qualifying for filter_len more cycles
// STABLE_HIGH | filtered level is 1, input agrees
// PEND_LOW    | input went low, qualifying for filter_len more cycles
module trig_activity_detect #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_BITS = 4,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   trig_in,
  input  logic [1:0]             edge_mode,
  input  logic [FILTER_BITS-1:0] filter_len,
  input  logic                   count_clear,
  output logic                   level,
  output logic                   activity,
  output logic [COUNT_WIDTH-1:0] event_count,
  output logic [15:0]            glitch_count,
  output logic                   count_saturated
);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    PEND_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    PEND_LOW    = 2'd3
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX      = '1;
  localparam logic [COUNT_WIDTH-1:0] CNT_NEAR_MAX = {{(COUNT_WIDTH-1){1'b1}}, 1'b0};

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync_q;

  state_t                 state, state_nx;
  logic [FILTER_BITS-1:0] fc, fc_nx;
  logic                   level_nx;
  logic                   activity_nx;
  logic                   glitch_nx;
  logic                   glitch_pulse;
  logic                   rise_acc, fall_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_ff <= '0;
    else     sync_ff <= {sync_ff[SYNC_STAGES-2:0], trig_in};
  end

  assign sync_q = sync_ff[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= STABLE_LOW;
      fc           <= '0;
      level        <= 1'b0;
      activity     <= 1'b0;
      glitch_pulse <= 1'b0;
    end else begin
      state        <= state_nx;
      fc           <= fc_nx;
      level        <= level_nx;
      activity     <= activity_nx;
      glitch_pulse <= glitch_nx;
    end
  end

  // filter_len is compared live with >=, so shortening it while a
  // transition is pending completes that transition on the next cycle.
  always_comb begin
    state_nx  = state;
    fc_nx     = fc;
    level_nx  = level;
    rise_acc  = 1'b0;
    fall_acc  = 1'b0;
    glitch_nx = 1'b0;
    case (state)
      STABLE_LOW: begin
        if (sync_q) begin
          if (filter_len == '0) begin
            level_nx = 1'b1;
            rise_acc = 1'b1;
            state_nx = STABLE_HIGH;
          end else begin
            fc_nx    = FILTER_BITS'(1);
            state_nx = PEND_HIGH;
          end
        end
      end
      PEND_HIGH: begin
        if (!sync_q) begin
          glitch_nx = 1'b1;
          state_nx  = STABLE_LOW;
        end else if (fc >= filter_len) begin
          level_nx = 1'b1;
          rise_acc = 1'b1;
          state_nx = STABLE_HIGH;
        end else begin
          fc_nx = fc + 1'b1;
        end
      end
      STABLE_HIGH: begin
        if (!sync_q) begin
          if (filter_len == '0) begin
            level_nx = 1'b0;
            fall_acc = 1'b1;
            state_nx = STABLE_LOW;
          end else begin
            fc_nx    = FILTER_BITS'(1);
            state_nx = PEND_LOW;
          end
        end
      end
      PEND_LOW: begin
        if (sync_q) begin
          glitch_nx = 1'b1;
          state_nx  = STABLE_HIGH;
        end else if (fc >= filter_len) begin
          level_nx = 1'b0;
          fall_acc = 1'b1;
          state_nx = STABLE_LOW;
        end else begin
          fc_nx = fc + 1'b1;
        end
      end
      default: state_nx = STABLE_LOW;
    endcase
    activity_nx = (rise_acc & edge_mode[0]) | (fall_acc & edge_mode[1]);
  end

  // A clear that coincides with an event or glitch keeps that occurrence,
  // so nothing is lost across a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_count     <= '0;
      count_saturated <= 1'b0;
    end else if (count_clear) begin
      event_count     <= {{(COUNT_WIDTH-1){1'b0}}, activity};
      count_saturated <= 1'b0;
    end else if (activity && event_count != CNT_MAX) begin
      event_count <= event_count + 1'b1;
      if (event_count == CNT_NEAR_MAX) count_saturated <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       glitch_count <= '0;
    else if (count_clear)                          glitch_count <= {15'd0, glitch_pulse};
    else if (glitch_pulse && glitch_count != 16'hFFFF) glitch_count <= glitch_count + 16'd1;
  end

endmodule

// File: tb/tb_trig_activity_detect.sv
module tb_trig_activity_detect;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trig_in = 1'b0;
  logic [1:0]  edge_mode = 2'b01;
  logic [3:0]  filter_len = 4'd0;
  logic        count_clear = 1'b0;

  logic        level, activity, count_saturated;
  logic [31:0] event_count;
  logic [15:0] glitch_count;

  logic        s_level, s_activity, s_count_saturated;
  logic [3:0]  s_event_count;
  logic [15:0] s_glitch_count;

  int checks = 0;
  int failures = 0;

  trig_activity_detect dut (
    .clk(clk), .rst(rst), .trig_in(trig_in), .edge_mode(edge_mode),
    .filter_len(filter_len), .count_clear(count_clear), .level(level),
    .activity(activity), .event_count(event_count), .glitch_count(glitch_count),
    .count_saturated(count_saturated)
  );

  trig_activity_detect #(.COUNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .trig_in(trig_in), .edge_mode(edge_mode),
    .filter_len(filter_len), .count_clear(count_clear), .level(s_level),
    .activity(s_activity), .event_count(s_event_count), .glitch_count(s_glitch_count),
    .count_saturated(s_count_saturated)
  );

  always #5 clk = ~clk;

  // one active edge, then return to the falling edge where we drive and sample
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    trig_in = 1'b0;
    count_clear = 1'b0;
    step(2);
    rst = 1'b0;
    step(2);
  endtask

  // drives hi cycles of 1 then lo cycles of 0, periods times; counts
  // activity pulses and level changes seen at the sample points
  task automatic run_wave(input int hi, input int lo, input int periods,
                          output int n_act, output int n_tog);
    logic prev;
    n_act = 0;
    n_tog = 0;
    prev  = level;
    for (int p = 0; p < periods; p++) begin
      for (int c = 0; c < hi + lo; c++) begin
        trig_in = (c < hi);
        step(1);
        if (activity) n_act++;
        if (level !== prev) n_tog++;
        prev = level;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1);
    checks++;
    if ({level, activity, count_saturated} !== 3'b000 || event_count !== 32'd0 || glitch_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_outputs: got level=%0b act=%0b sat=%0b ev=%0d gl=%0d required all 0",
               level, activity, count_saturated, event_count, glitch_count);
    end
    checks++;
    if ({s_level, s_activity, s_count_saturated} !== 3'b000 || s_event_count !== 4'd0) begin
      failures++;
      $display("FAIL reset_outputs_w4: got level=%0b act=%0b sat=%0b ev=%0d required all 0",
               s_level, s_activity, s_count_saturated, s_event_count);
    end
  endtask

  task automatic test_basic_rise();
    apply_reset();
    edge_mode = 2'b01;
    filter_len = 4'd0;
    trig_in = 1'b1;
    step(2);
    checks++;
    if (level !== 1'b0 || activity !== 1'b0) begin
      failures++;
      $display("FAIL rise_edge2: got level=%0b act=%0b required 0 0", level, activity);
    end
    step(1);
    checks++;
    if (level !== 1'b1 || activity !== 1'b1) begin
      failures++;
      $display("FAIL rise_edge3: got level=%0b act=%0b required 1 1", level, activity);
    end
    step(1);
    checks++;
    if (activity !== 1'b0 || event_count !== 32'd1) begin
      failures++;
      $display("FAIL rise_edge4: got act=%0b ev=%0d required 0 1", activity, event_count);
    end
  endtask

  task automatic test_filter();
    int n_act, n_tog;
    logic dropped;
    apply_reset();
    edge_mode = 2'b01;
    filter_len = 4'd3;
    run_wave(3, 12, 1, n_act, n_tog);
    checks++;
    if (n_act != 0 || n_tog != 0 || glitch_count !== 16'd1) begin
      failures++;
      $display("FAIL filter_3cyc: got act=%0d tog=%0d gl=%0d required 0 0 1", n_act, n_tog, glitch_count);
    end
    run_wave(4, 12, 1, n_act, n_tog);
    checks++;
    if (n_act != 1 || n_tog != 2 || event_count !== 32'd1 || glitch_count !== 16'd1) begin
      failures++;
      $display("FAIL filter_4cyc: got act=%0d tog=%0d ev=%0d gl=%0d required 1 2 1 1",
               n_act, n_tog, event_count, glitch_count);
    end
    // short low dip while high must be rejected as well
    trig_in = 1'b1;
    step(10);
    dropped = 1'b0;
    trig_in = 1'b0;
    step(2);
    trig_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (!level) dropped = 1'b1;
    end
    checks++;
    if (dropped !== 1'b0 || glitch_count !== 16'd2 || event_count !== 32'd2) begin
      failures++;
      $display("FAIL filter_low_dip: got dropped=%0b gl=%0d ev=%0d required 0 2 2",
               dropped, glitch_count, event_count);
    end
  endtask

  task automatic test_edge_modes();
    int n_act, n_tog;
    apply_reset();
    filter_len = 4'd0;
    edge_mode = 2'b11;
    run_wave(10, 10, 5, n_act, n_tog);
    checks++;
    if (n_act != 10 || event_count !== 32'd10) begin
      failures++;
      $display("FAIL mode_both: got act=%0d ev=%0d required 10 10", n_act, event_count);
    end
    apply_reset();
    edge_mode = 2'b10;
    run_wave(10, 10, 5, n_act, n_tog);
    checks++;
    if (n_act != 5 || event_count !== 32'd5) begin
      failures++;
      $display("FAIL mode_fall: got act=%0d ev=%0d required 5 5", n_act, event_count);
    end
    apply_reset();
    edge_mode = 2'b00;
    run_wave(10, 10, 5, n_act, n_tog);
    checks++;
    if (n_act != 0 || event_count !== 32'd0 || n_tog != 10) begin
      failures++;
      $display("FAIL mode_none: got act=%0d ev=%0d tog=%0d required 0 0 10", n_act, event_count, n_tog);
    end
  endtask

  task automatic test_saturation();
    int n_act, n_tog;
    apply_reset();
    filter_len = 4'd0;
    edge_mode = 2'b11;
    run_wave(4, 4, 7, n_act, n_tog);
    step(3);
    checks++;
    if (s_event_count !== 4'd14 || s_count_saturated !== 1'b0) begin
      failures++;
      $display("FAIL sat_pre: got ev=%0d sat=%0b required 14 0", s_event_count, s_count_saturated);
    end
    run_wave(4, 4, 1, n_act, n_tog);
    trig_in = 1'b1;
    step(5);
    checks++;
    if (s_event_count !== 4'd15 || s_count_saturated !== 1'b1 || event_count !== 32'd17) begin
      failures++;
      $display("FAIL sat_hold: got ev4=%0d sat=%0b ev32=%0d required 15 1 17",
               s_event_count, s_count_saturated, event_count);
    end
    count_clear = 1'b1;
    step(1);
    count_clear = 1'b0;
    checks++;
    if (s_event_count !== 4'd0 || s_count_saturated !== 1'b0 || event_count !== 32'd0) begin
      failures++;
      $display("FAIL sat_clear: got ev4=%0d sat=%0b ev32=%0d required 0 0 0",
               s_event_count, s_count_saturated, event_count);
    end
  endtask

  task automatic test_clear_with_activity();
    int n_act, n_tog;
    apply_reset();
    filter_len = 4'd0;
    edge_mode = 2'b11;
    run_wave(4, 4, 1, n_act, n_tog);
    step(3);
    checks++;
    if (event_count !== 32'd2) begin
      failures++;
      $display("FAIL clr_pre: got ev=%0d required 2", event_count);
    end
    trig_in = 1'b1;
    step(3);
    checks++;
    if (activity !== 1'b1) begin
      failures++;
      $display("FAIL clr_act: got act=%0b required 1", activity);
    end
    count_clear = 1'b1;
    step(1);
    count_clear = 1'b0;
    checks++;
    if (event_count !== 32'd1) begin
      failures++;
      $display("FAIL clr_coincide: got ev=%0d required 1", event_count);
    end
  endtask

  task automatic test_reset_pending();
    int found;
    logic act_at;
    apply_reset();
    filter_len = 4'd0;
    edge_mode = 2'b01;
    trig_in = 1'b1;
    step(5);
    trig_in = 1'b0;
    step(5);
    filter_len = 4'd3;
    trig_in = 1'b1;
    step(4);
    checks++;
    if (event_count !== 32'd1 || level !== 1'b0) begin
      failures++;
      $display("FAIL pend_pre: got ev=%0d level=%0b required 1 0", event_count, level);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({level, activity, count_saturated} !== 3'b000 || event_count !== 32'd0 || glitch_count !== 16'd0) begin
      failures++;
      $display("FAIL pend_async_reset: got level=%0b act=%0b ev=%0d gl=%0d required 0 0 0 0",
               level, activity, event_count, glitch_count);
    end
    step(2);
    rst = 1'b0;
    found = 0;
    act_at = 1'b0;
    for (int i = 1; i <= 20 && found == 0; i++) begin
      step(1);
      if (level) begin
        found = i;
        act_at = activity;
      end
    end
    checks++;
    if (found != 6 || act_at !== 1'b1) begin
      failures++;
      $display("FAIL pend_rereport: got edge=%0d act=%0b required 6 1 (0 means timeout)", found, act_at);
    end
  endtask

  initial begin
    test_reset();
    test_basic_rise();
    test_filter();
    test_edge_modes();
    test_saturation();
    test_clear_with_activity();
    test_reset_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
